fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller in front of the combinational instruction ROM (instructmem).
//  - Owns the fetch PC and drives the ROM address.
//  - Buffers fetched {pc, instr} pairs in a small queue and hands them to decode over valid/ready.
//  - Applies branch redirects from the pipeline, which flush the queue.
//  - Stops fetching and flags a fault on a misaligned or out-of-range fetch address, instead of passing 'x downstream.
// PARAMETERS
//  MEM_BYTES  1024  ROM size in bytes; power of two, > 4
//  DEPTH      2     fetch queue entries; >= 1
//  RESET_PC   0     fetch PC loaded at reset; word aligned
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-low (0 = reset)
//  imem_addr      out  64  ROM byte address; combinational copy of fetch_pc
//  imem_instr     in   32  ROM read data; combinational from imem_addr
//  out_valid      out  1   queue head valid
//  out_ready      in   1   decode accepts head this cycle
//  out_instr      out  32  head instruction
//  out_pc         out  64  head PC
//  redirect_valid in   1   branch/jump taken; flush and refetch
//  redirect_pc    in   64  new fetch PC
//  fault          out  1   sticky; high while in FAULT state
//  fault_pc       out  64  address that faulted
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - fetch_pc=RESET_PC, queue empty, state=FETCH.
//  - out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
//  Handshake and timing:
//  - pop = out_valid & out_ready.
//  - out_* hold stable while out_valid & !out_ready.
//  - out_instr/out_pc are 0 when the queue is empty.
//  - Latency: first instruction has out_valid=1 in the cycle after reset releases.
//  - Throughput: 1 instruction/cycle with out_ready held high.
//  Legal fetch address:
//  - legal = (fetch_pc[1:0]==0) && (fetch_pc <= MEM_BYTES-4).
//  - Compare at 64 bits. fetch_pc+3 must not wrap, so use the <= form.
//  States: FETCH, FAULT.
//  FETCH, per cycle, in priority order:
//  1. redirect_valid:
//     - queue cleared; fetch_pc<=redirect_pc; no push this cycle.
//     - A pop in the same cycle still counts as a completed transfer.
//  2. !legal:
//     - no push; state<=FAULT; fault<=1; fault_pc<=fetch_pc.
//     - Queue contents are kept and still drain via pop.
//  3. space available: push {fetch_pc, imem_instr}; fetch_pc<=fetch_pc+4.
//     - space = (count<DEPTH) || pop. Push and pop may occur together when full.
//  4. otherwise: stall; fetch_pc holds.
//  FAULT:
//  - No pushes; the queue drains normally.
//  - redirect_valid: clears the queue, fault<=0, fetch_pc<=redirect_pc, state<=FETCH.
//    The new PC is legality-checked on the next cycle (it may fault again).
//  Boundaries:
//  - Empty + pop: impossible, since out_valid=0.
//  - Redirect to the same PC as fetch_pc still flushes the queue.
//  - Last word (MEM_BYTES-4) is legal. The next increment faults, with fault_pc=MEM_BYTES.
//  - Reset mid-stream overrides redirect and pop.
//  Widths:
//  - count is $clog2(DEPTH+1) bits.
//  - Queue pointers wrap modulo DEPTH (DEPTH need not be a power of two).
// STRUCTURE
//  Package fetch_pkg:
//  - typedef enum logic {FETCH, FAULT} fetch_state_t;
//  - typedef struct packed {logic [63:0] pc; logic [31:0] instr;} fetch_entry_t;
//  - localparam INSTR_BYTES = 4.
//  Sub-module fetch_queue #(DEPTH): circular buffer of fetch_entry_t.
//  - Ports: push, pop, flush, din, dout, count, empty, full.
//  - flush has priority over push.
//  Top level holds fetch_pc, the state register, and the legality check.
// TESTING (MEM_BYTES=1024, DEPTH=2, RESET_PC=0, ROM word i = 32'hA000_0000+i)
//  1. Reset, then out_ready=1 for 5 cycles -> out_pc 0,4,8,12,16 on consecutive cycles;
//     out_instr A0000000..A0000004; fault=0.
//  2. out_ready=0 for 4 cycles -> queue fills with pc 0,4; imem_addr holds 8; out_* stable.
//     Then ready=1 -> 0,4,8 with no gap or duplicate.
//  3. Redirect to 0x100 while the queue holds 2 entries -> next cycle out_valid=0;
//     following cycle out_pc=0x100, out_instr=A0000040.
//  4. Redirect to 0x3FC -> delivers 0x3FC, then fault=1, fault_pc=0x400, out_valid drops;
//     redirect to 0 -> fault=0 and fetch resumes at pc 0.
//  5. Redirect to 0x102 -> FAULT with fault_pc=0x102 and no entry pushed.
//  6. Assert reset (0) mid-stream alongside redirect_valid=1 -> all outputs 0;
//     after release, first out_pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic {FETCH, FAULT} fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, instr} pairs; flush beats push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= nxt(tail_q);
      if (pop)  head_q <= nxt(head_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem_q[tail_q] <= din;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign dout  = empty ? '0 : mem_q[head_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: drives the ROM, queues fetched words for decode,
// applies redirects and parks in FAULT on an illegal fetch address.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int          DEPTH     = 2,
  parameter logic [63:0] RESET_PC  = '0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fault,
  output logic [63:0] fault_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state_q;
  logic [63:0]   fetch_pc_q, fault_pc_q;
  logic          fault_q;

  fetch_entry_t  q_din, q_dout;
  logic [CW-1:0] q_count;
  logic          q_empty, q_full;
  logic          pop, push, space, legal;
  logic          unused_count;

  // The <= form avoids wrap of fetch_pc+3 near the top of the address space.
  assign legal = (fetch_pc_q[1:0] == 2'b00) &&
                 (fetch_pc_q <= (64'(MEM_BYTES) - 64'(INSTR_BYTES)));
  assign pop   = out_valid & out_ready;
  assign space = !q_full || pop;
  assign push  = (state_q == FETCH) && !redirect_valid && legal && space;

  assign q_din.pc    = fetch_pc_q;
  assign q_din.instr = imem_instr;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  assign unused_count = ^q_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
          end else if (!legal) begin
            state_q    <= FAULT;
            fault_q    <= 1'b1;
            fault_pc_q <= fetch_pc_q;
          end else if (space) begin
            fetch_pc_q <= fetch_pc_q + 64'(INSTR_BYTES);
          end
        end
        FAULT: begin
          // New PC is only checked next cycle, so it may fault again.
          if (redirect_valid) begin
            state_q    <= FETCH;
            fault_q    <= 1'b0;
            fetch_pc_q <= redirect_pc;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = !q_empty;
  assign out_pc    = q_dout.pc;
  assign out_instr = q_dout.instr;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

endmodule
